// File: rtl/bsg_bus_arbiter.sv
// Two-requester round-robin arbiter and single-beat access sequencer for the
// BSG register bank; every output is registered.
module bsg_bus_arbiter #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] ADDR_BASE  = DATA_WIDTH'(8'h10),
    parameter int                    NUM_REGS   = 3
) (
    input  logic                  G_CLK_TX,
    input  logic                  rst,
    input  logic                  REQ_A,
    input  logic                  WR_A,
    input  logic [DATA_WIDTH-1:0] ADDR_A,
    input  logic [DATA_WIDTH-1:0] WDATA_A,
    input  logic                  REQ_B,
    input  logic                  WR_B,
    input  logic [DATA_WIDTH-1:0] ADDR_B,
    input  logic [DATA_WIDTH-1:0] WDATA_B,
    output logic                  GNT_A,
    output logic                  GNT_B,
    output logic                  DONE_A,
    output logic                  DONE_B,
    output logic                  ERR_A,
    output logic                  ERR_B,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  BUSY,
    output logic                  BUS_SEL,
    output logic                  BUS_WR,
    output logic [DATA_WIDTH-1:0] BUS_ADDR,
    output logic [DATA_WIDTH-1:0] BUS_WDATA,
    input  logic [DATA_WIDTH-1:0] BUS_RDATA
);

    // state   | meaning
    // IDLE    | arbitrate, latch winning command
    // ACCESS  | bank strobe driven from command register
    // WAIT_RD | bank returns read data, captured at end of cycle
    // DONE    | completion (and error) pulse to the owner
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_WAIT_RD = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [DATA_WIDTH:0] NUM_REGS_W = (DATA_WIDTH+1)'(NUM_REGS);

    state_t                state, state_nxt;
    logic                  last_grant, last_grant_nxt;   // 0 = A, 1 = B
    logic                  cmd_owner, cmd_owner_nxt;     // 0 = A, 1 = B
    logic                  cmd_wr, cmd_wr_nxt;
    logic [DATA_WIDTH-1:0] cmd_addr, cmd_addr_nxt;
    logic [DATA_WIDTH-1:0] cmd_wdata, cmd_wdata_nxt;

    logic                  win_b;
    logic                  win_wr;
    logic [DATA_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic [DATA_WIDTH:0]   win_off;
    logic                  win_ok;

    logic                  gnt_a_d, gnt_b_d, done_a_d, done_b_d, err_a_d, err_b_d;
    logic                  busy_d, bus_sel_d, bus_wr_d;
    logic [DATA_WIDTH-1:0] rdata_d, bus_addr_d, bus_wdata_d;

    always_ff @(posedge G_CLK_TX) begin
        if (rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            cmd_owner  <= 1'b0;
            cmd_wr     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            GNT_A      <= 1'b0;
            GNT_B      <= 1'b0;
            DONE_A     <= 1'b0;
            DONE_B     <= 1'b0;
            ERR_A      <= 1'b0;
            ERR_B      <= 1'b0;
            RDATA      <= '0;
            BUSY       <= 1'b0;
            BUS_SEL    <= 1'b0;
            BUS_WR     <= 1'b0;
            BUS_ADDR   <= '0;
            BUS_WDATA  <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            cmd_owner  <= cmd_owner_nxt;
            cmd_wr     <= cmd_wr_nxt;
            cmd_addr   <= cmd_addr_nxt;
            cmd_wdata  <= cmd_wdata_nxt;
            GNT_A      <= gnt_a_d;
            GNT_B      <= gnt_b_d;
            DONE_A     <= done_a_d;
            DONE_B     <= done_b_d;
            ERR_A      <= err_a_d;
            ERR_B      <= err_b_d;
            RDATA      <= rdata_d;
            BUSY       <= busy_d;
            BUS_SEL    <= bus_sel_d;
            BUS_WR     <= bus_wr_d;
            BUS_ADDR   <= bus_addr_d;
            BUS_WDATA  <= bus_wdata_d;
        end
    end

    // B wins when it is alone, or when both request and A had the last grant.
    always_comb begin
        win_b     = REQ_B && (!REQ_A || !last_grant);
        win_wr    = win_b ? WR_B    : WR_A;
        win_addr  = win_b ? ADDR_B  : ADDR_A;
        win_wdata = win_b ? WDATA_B : WDATA_A;
        win_off   = {1'b0, win_addr} - {1'b0, ADDR_BASE};
        win_ok    = win_off < NUM_REGS_W;

        state_nxt      = state;
        last_grant_nxt = last_grant;
        cmd_owner_nxt  = cmd_owner;
        cmd_wr_nxt     = cmd_wr;
        cmd_addr_nxt   = cmd_addr;
        cmd_wdata_nxt  = cmd_wdata;

        case (state)
            S_IDLE: begin
                if (REQ_A || REQ_B) begin
                    last_grant_nxt = win_b;
                    cmd_owner_nxt  = win_b;
                    cmd_wr_nxt     = win_wr;
                    cmd_addr_nxt   = win_addr;
                    cmd_wdata_nxt  = win_wdata;
                    state_nxt      = win_ok ? S_ACCESS : S_DONE;
                end
            end
            S_ACCESS:  state_nxt = cmd_wr ? S_DONE : S_WAIT_RD;
            S_WAIT_RD: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Output values for the cycle about to start, derived from the next state
    // and the (possibly just latched) command register contents.
    always_comb begin
        gnt_a_d     = 1'b0;
        gnt_b_d     = 1'b0;
        done_a_d    = 1'b0;
        done_b_d    = 1'b0;
        err_a_d     = 1'b0;
        err_b_d     = 1'b0;
        rdata_d     = '0;
        busy_d      = (state_nxt != S_IDLE);
        bus_sel_d   = 1'b0;
        bus_wr_d    = 1'b0;
        bus_addr_d  = '0;
        bus_wdata_d = '0;

        if (state == S_IDLE && state_nxt != S_IDLE) begin
            gnt_a_d = !cmd_owner_nxt;
            gnt_b_d = cmd_owner_nxt;
        end

        if (state_nxt == S_ACCESS) begin
            bus_sel_d   = 1'b1;
            bus_wr_d    = cmd_wr_nxt;
            bus_addr_d  = cmd_addr_nxt;
            bus_wdata_d = cmd_wdata_nxt;
        end

        if (state_nxt == S_DONE) begin
            done_a_d = !cmd_owner_nxt;
            done_b_d = cmd_owner_nxt;
            // Straight from IDLE to DONE only happens for a rejected address.
            if (state == S_IDLE) begin
                err_a_d = !cmd_owner_nxt;
                err_b_d = cmd_owner_nxt;
            end
            if (state == S_WAIT_RD) begin
                rdata_d = BUS_RDATA;
            end
        end
    end

endmodule
